// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM states, frame width
// and the smallest supported bit period.
package uart_pkg;

    localparam int unsigned UART_DATA_W  = 8;
    localparam logic [15:0] UART_MIN_CPB = 16'd4;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receiver-side serial input, configuration and received-byte outputs.
interface uart_rx_os_if;
    import uart_pkg::*;

    logic                   rx_i;
    logic                   rx_en_i;
    logic [15:0]            clks_per_bit;
    logic [UART_DATA_W-1:0] rx_o;
    logic                   rx_valid_o;
    logic                   frame_err_o;
    logic                   break_o;
    logic                   busy_o;

    modport master (
        output rx_i, rx_en_i, clks_per_bit,
        input  rx_o, rx_valid_o, frame_err_o, break_o, busy_o
    );

    modport slave (
        input  rx_i, rx_en_i, clks_per_bit,
        output rx_o, rx_valid_o, frame_err_o, break_o, busy_o
    );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the raw serial line plus a falling-edge detector.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic rx_i,
    output logic rx_s,
    output logic fall
);

    logic q1, q2, rx_p;

    // Flops reset high so an idle line never looks like a start edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q1   <= 1'b1;
            q2   <= 1'b1;
            rx_p <= 1'b1;
        end else begin
            q1   <= rx_i;
            q2   <= q1;
            rx_p <= q2;
        end
    end

    assign rx_s = q2;
    assign fall = rx_p & ~q2;

endmodule

// File: rtl/uart_rx_os.sv
// 8N1 UART receiver with three-sample mid-bit voting, false-start rejection,
// framing-error reporting and break detection.
module uart_rx_os
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    uart_rx_os_if.slave bus
);

    rx_state_e              state_q, state_d;
    logic                   rx_s, fall;
    logic [15:0]            cpb_q, cnt_q, half;
    logic [2:0]             idx_q;
    logic [UART_DATA_W-1:0] sh_q, rx_q, rx_d;
    logic                   v0_q, v1_q, vote;
    logic                   at_lo, at_mid, at_hi, at_end;
    logic                   valid_q, valid_d, err_q, err_d, brk_q, busy_q;

    uart_rx_sync u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .rx_i  (bus.rx_i),
        .rx_s  (rx_s),
        .fall  (fall)
    );

    assign half   = cpb_q >> 1;
    assign at_lo  = (cnt_q == half - 16'd1);
    assign at_mid = (cnt_q == half);
    assign at_hi  = (cnt_q == half + 16'd1);
    assign at_end = (cnt_q == cpb_q - 16'd1);
    // Third sample is the live line, so the decision lands in the cnt = M+1 cycle.
    assign vote   = maj3(v0_q, v1_q, rx_s);

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= RX_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (!bus.rx_en_i) begin
            state_d = RX_IDLE;
        end else begin
            case (state_q)
                RX_IDLE:  if (fall && bus.clks_per_bit >= UART_MIN_CPB) state_d = RX_START;
                RX_START: begin
                    if (at_hi && vote) state_d = RX_IDLE;
                    else if (at_end)   state_d = RX_DATA;
                end
                RX_DATA:  if (at_end && idx_q == 3'(UART_DATA_W - 1)) state_d = RX_STOP;
                RX_STOP: begin
                    if (at_hi) begin
                        if (vote)            state_d = RX_IDLE;
                        else if (sh_q == '0) state_d = RX_BREAK;
                        else                 state_d = RX_IDLE;
                    end
                end
                RX_BREAK: if (rx_s && at_end) state_d = RX_IDLE;
                default:  state_d = RX_IDLE;
            endcase
        end
    end

    always_comb begin
        valid_d = 1'b0;
        err_d   = 1'b0;
        rx_d    = rx_q;
        if (bus.rx_en_i && state_q == RX_STOP && at_hi) begin
            if (vote) begin
                valid_d = 1'b1;
                rx_d    = sh_q;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            brk_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            rx_q    <= rx_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            brk_q   <= (state_d == RX_BREAK);
            busy_q  <= (state_d != RX_IDLE);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cpb_q <= '0;
            cnt_q <= '0;
            idx_q <= '0;
            sh_q  <= '0;
            v0_q  <= 1'b1;
            v1_q  <= 1'b1;
        end else begin
            if (state_q == RX_IDLE) begin
                cpb_q <= bus.clks_per_bit;
                idx_q <= '0;
            end
            // In BREAK the counter measures consecutive high cycles instead of bit time.
            if (state_q == RX_IDLE || state_d != state_q) cnt_q <= '0;
            else if (at_end || (state_q == RX_BREAK && !rx_s)) cnt_q <= '0;
            else cnt_q <= cnt_q + 16'd1;
            if (at_lo)  v0_q <= rx_s;
            if (at_mid) v1_q <= rx_s;
            if (state_q == RX_DATA && at_hi)  sh_q  <= {vote, sh_q[UART_DATA_W-1:1]};
            if (state_q == RX_DATA && at_end) idx_q <= idx_q + 3'd1;
        end
    end

    assign bus.rx_o        = rx_q;
    assign bus.rx_valid_o  = valid_q;
    assign bus.frame_err_o = err_q;
    assign bus.break_o     = brk_q;
    assign bus.busy_o      = busy_q;

endmodule
